// File: rtl/uart_tx_ctrl.sv
// Transmit-side frame builder for the MPU UART link: 11-byte frames streamed over valid/ready.
// Optional periodic auto-trigger is compiled in with `define UART_TX_AUTO_EN.
module uart_tx_ctrl #(
    parameter logic [7:0]  HEADER      = 8'h55,
    parameter int unsigned FRAME_GAP   = 16,
    parameter int unsigned AUTO_PERIOD = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  reg_tx_cmd,
    input  logic [15:0] reg_tx_word0,
    input  logic [15:0] reg_tx_word1,
    input  logic [15:0] reg_tx_word2,
    input  logic [15:0] reg_tx_word3,
    input  logic        tx_start,
    input  logic        reg_auto_en,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic        tx_busy,
    output logic [31:0] reg_frame_num,
    output logic [15:0] reg_drop_num,
    input  logic        reg_num_clr
);

    localparam int unsigned GapW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_CMD  = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4,
        S_GAP  = 3'd5
    } state_e;

    state_e               state_q;
    logic [7:0]           cmd_q;
    logic [3:0][15:0]     words_q;
    logic [2:0]           byte_idx_q;
    logic [GapW-1:0]      gap_cnt_q;
    logic [7:0]           csum;
    logic                 trig;
    logic                 accept;
    logic                 frame_done;
    logic                 drop;

    // ------------------------------------------------------------------
    // Trigger source
    // ------------------------------------------------------------------
`ifdef UART_TX_AUTO_EN
    localparam logic [31:0] AutoLast = 32'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);

    logic [31:0] auto_cnt_q;
    logic        auto_trig;

    assign auto_trig = reg_auto_en && (auto_cnt_q == AutoLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt_q <= '0;
        end else if (!reg_auto_en || auto_trig) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_q + 32'd1;
        end
    end

    assign trig = tx_start | auto_trig;
`else
    logic unused_auto_en;
    logic [31:0] unused_auto_period;

    assign unused_auto_en     = reg_auto_en;
    assign unused_auto_period = 32'(AUTO_PERIOD);
    assign trig               = tx_start;
`endif

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] data_byte(input logic [3:0][15:0] w, input logic [2:0] idx);
        logic [15:0] word;
        word = w[idx[2:1]];
        return idx[0] ? word[15:8] : word[7:0];
    endfunction

    // Checksum is purely a function of the snapshot, so it is settled long before S_SUM.
    always_comb begin
        csum = HEADER + cmd_q;
        for (int i = 0; i < 4; i++) begin
            csum = csum + words_q[i][7:0] + words_q[i][15:8];
        end
    end

    assign accept     = tx_vld && tx_rdy;
    assign tx_busy    = (state_q != S_IDLE);
    assign frame_done = (state_q == S_SUM) && accept;
    assign drop       = trig && (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Frame FSM with registered byte/valid outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_data    <= 8'h00;
            tx_vld     <= 1'b0;
            cmd_q      <= 8'h00;
            words_q    <= '0;
            byte_idx_q <= 3'd0;
            gap_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        cmd_q      <= reg_tx_cmd;
                        words_q[0] <= reg_tx_word0;
                        words_q[1] <= reg_tx_word1;
                        words_q[2] <= reg_tx_word2;
                        words_q[3] <= reg_tx_word3;
                        tx_data    <= HEADER;
                        tx_vld     <= 1'b1;
                        state_q    <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (accept) begin
                        tx_data <= cmd_q;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (accept) begin
                        tx_data    <= data_byte(words_q, 3'd0);
                        byte_idx_q <= 3'd0;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (byte_idx_q == 3'd7) begin
                            tx_data <= csum;
                            state_q <= S_SUM;
                        end else begin
                            tx_data    <= data_byte(words_q, byte_idx_q + 3'd1);
                            byte_idx_q <= byte_idx_q + 3'd1;
                        end
                    end
                end
                S_SUM: begin
                    if (accept) begin
                        tx_vld    <= 1'b0;
                        gap_cnt_q <= '0;
                        state_q   <= (FRAME_GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_vld  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Readback counters; clear wins over a same-cycle increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_frame_num <= 32'd0;
            reg_drop_num  <= 16'd0;
        end else if (reg_num_clr) begin
            reg_frame_num <= 32'd0;
            reg_drop_num  <= 16'd0;
        end else begin
            if (frame_done) begin
                reg_frame_num <= reg_frame_num + 32'd1;
            end
            if (drop && (reg_drop_num != 16'hFFFF)) begin
                reg_drop_num <= reg_drop_num + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: queue-based frame model checked every cycle.
module tb_uart_tx_ctrl;

    localparam int unsigned GAP = 16;
`ifdef UART_TX_AUTO_EN
    localparam int unsigned PERIOD = 200;
`else
    localparam int unsigned PERIOD = 1000000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  reg_tx_cmd;
    logic [15:0] reg_tx_word0, reg_tx_word1, reg_tx_word2, reg_tx_word3;
    logic        tx_start;
    logic        reg_auto_en;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        tx_busy;
    logic [31:0] reg_frame_num;
    logic [15:0] reg_drop_num;
    logic        reg_num_clr;

    uart_tx_ctrl #(
        .HEADER      (8'h55),
        .FRAME_GAP   (GAP),
        .AUTO_PERIOD (PERIOD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_tx_cmd    (reg_tx_cmd),
        .reg_tx_word0  (reg_tx_word0),
        .reg_tx_word1  (reg_tx_word1),
        .reg_tx_word2  (reg_tx_word2),
        .reg_tx_word3  (reg_tx_word3),
        .tx_start      (tx_start),
        .reg_auto_en   (reg_auto_en),
        .tx_data       (tx_data),
        .tx_vld        (tx_vld),
        .tx_rdy        (tx_rdy),
        .tx_busy       (tx_busy),
        .reg_frame_num (reg_frame_num),
        .reg_drop_num  (reg_drop_num),
        .reg_num_clr   (reg_num_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a queue of bytes still to be delivered, then GAP idle cycles.
    logic [7:0]  mq[$];
    int          gap_left;
    logic [31:0] m_frames;
    logic [15:0] m_drops;
    int          auto_cnt;
    logic        checking = 1'b0;
    logic [7:0]  dut_log[$];
    logic [7:0]  exp_basic [11];

    function automatic logic model_busy();
        return (mq.size() > 0) || (gap_left > 0);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic       mtrig;
        logic       was_busy;
        logic [15:0] wv [4];
        logic [7:0] s;
        if (rst) begin
            mq.delete();
            gap_left = 0;
            m_frames = 0;
            m_drops  = 0;
            auto_cnt = 0;
        end else begin
            was_busy = model_busy();
            mtrig    = tx_start;
`ifdef UART_TX_AUTO_EN
            if (reg_auto_en) begin
                if (auto_cnt == int'(PERIOD) - 1) begin
                    mtrig    = 1'b1;
                    auto_cnt = 0;
                end else begin
                    auto_cnt++;
                end
            end else begin
                auto_cnt = 0;
            end
`endif
            if (tx_vld && tx_rdy) dut_log.push_back(tx_data);
            if (mq.size() > 0) begin
                if (tx_rdy) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        m_frames = m_frames + 1;
                        gap_left = GAP;
                    end
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (mtrig) begin
                if (was_busy) begin
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 1;
                end else begin
                    wv = '{reg_tx_word0, reg_tx_word1, reg_tx_word2, reg_tx_word3};
                    mq.push_back(8'h55);
                    mq.push_back(reg_tx_cmd);
                    s = 8'h55 + reg_tx_cmd;
                    for (int i = 0; i < 4; i++) begin
                        mq.push_back(wv[i][7:0]);
                        mq.push_back(wv[i][15:8]);
                        s = s + wv[i][7:0] + wv[i][15:8];
                    end
                    mq.push_back(s);
                end
            end
            if (reg_num_clr) begin
                m_frames = 0;
                m_drops  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && checking) begin
            check("tx_vld", 32'(tx_vld), 32'(mq.size() > 0));
            if (mq.size() > 0) check("tx_data", 32'(tx_data), 32'(mq[0]));
            check("tx_busy", 32'(tx_busy), 32'(model_busy()));
            check("frame_num", reg_frame_num, m_frames);
            check("drop_num", 32'(reg_drop_num), 32'(m_drops));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (tx_busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(tx_busy), 32'd0);
    endtask

    task automatic set_basic();
        reg_tx_cmd   = 8'h53;
        reg_tx_word0 = 16'h1234;
        reg_tx_word1 = 16'h0001;
        reg_tx_word2 = 16'h0000;
        reg_tx_word3 = 16'h0A0B;
    endtask

    task automatic check_log_basic(input string name);
        check({name, "_len"}, 32'(dut_log.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < dut_log.size()) check(name, 32'(dut_log[i]), 32'(exp_basic[i]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        exp_basic = '{8'h55, 8'h53, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h0A, 8'h04};
        rst = 1'b1;
        tx_start = 1'b0;
        reg_auto_en = 1'b0;
        reg_num_clr = 1'b0;
        tx_rdy = 1'b0;
        set_basic();
        repeat (3) tick();
        check("rst_vld", 32'(tx_vld), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_frames", reg_frame_num, 32'd0);
        check("rst_drops", 32'(reg_drop_num), 32'd0);
        rst = 1'b0;
        checking = 1'b1;
        tick();

        // Basic frame, back to back
        tx_rdy = 1'b1;
        dut_log.delete();
        pulse_start();
        check("basic_first_vld", 32'(tx_vld), 32'd1);
        check("basic_first_data", 32'(tx_data), 32'h55);
        repeat (11) tick();
        check_log_basic("basic_byte");
        check("basic_frames", reg_frame_num, 32'd1);
        repeat (GAP - 1) tick();
        check("basic_gap_busy", 32'(tx_busy), 32'd1);
        tick();
        check("basic_gap_done", 32'(tx_busy), 32'd0);

        // Backpressure: ready one cycle in four
        dut_log.delete();
        tx_rdy = 1'b0;
        pulse_start();
        for (int c = 0; c < 60; c++) begin
            tx_rdy = (c % 4 == 3);
            tick();
        end
        tx_rdy = 1'b1;
        wait_idle(100);
        check_log_basic("bp_byte");
        check("bp_frames", reg_frame_num, 32'd2);

        // Snapshot: word0 changes after the header is accepted
        dut_log.delete();
        pulse_start();
        tick();
        reg_tx_word0 = 16'hFFFF;
        wait_idle(100);
        check_log_basic("snap_byte");
        set_basic();

        // Drops during a frame, then clear
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            pulse_start();
        end
        wait_idle(100);
        check("drop_count", 32'(reg_drop_num), 32'd3);
        check("drop_frames", reg_frame_num, 32'd4);
        reg_num_clr = 1'b1;
        tick();
        reg_num_clr = 1'b0;
        check("clr_frames", reg_frame_num, 32'd0);
        check("clr_drops", 32'(reg_drop_num), 32'd0);

        // Reset in the middle of the data bytes
        pulse_start();
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_vld", 32'(tx_vld), 32'd0);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        dut_log.delete();
        pulse_start();
        wait_idle(100);
        check_log_basic("post_rst_byte");
        check("post_rst_frames", reg_frame_num, 32'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tx_rdy      = ($urandom % 4) != 0;
            tx_start    = ($urandom % 12) == 0;
            reg_num_clr = ($urandom % 200) == 0;
            if ($urandom % 8 == 0) begin
                reg_tx_cmd   = 8'($urandom);
                reg_tx_word0 = 16'($urandom);
                reg_tx_word1 = 16'($urandom);
                reg_tx_word2 = 16'($urandom);
                reg_tx_word3 = 16'($urandom);
            end
            tick();
        end
        tx_start = 1'b0;
        reg_num_clr = 1'b0;
        tx_rdy = 1'b1;
        wait_idle(200);

`ifdef UART_TX_AUTO_EN
        reg_num_clr = 1'b1;
        tick();
        reg_num_clr = 1'b0;
        reg_auto_en = 1'b1;
        repeat (650) tick();
        check("auto_frames", reg_frame_num, 32'd3);
        reg_auto_en = 1'b0;
        repeat (400) tick();
        check("auto_stopped", reg_frame_num, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
